// File: rtl/id_ex_pkg.sv
// Shared ID/EX definitions: default field widths, the stage payload layout and the bubble control value.
package id_ex_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int CTRL_W  = 9;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [DATA_W-1:0]  r1;
        logic [DATA_W-1:0]  r2;
        logic [DATA_W-1:0]  address;
        logic [DATA_W-1:0]  pc;
        logic [CTRL_W-1:0]  ctrl;
        logic [ALUOP_W-1:0] alu_ctrl;
        logic               mem_read;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
    } id_ex_payload_t;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_stage_load_use_detect.sv
// Load-use hazard detector: a younger instruction reading the rt of a stored, still-pending load.
module load_use_detect #(
    parameter int REG_W = id_ex_pkg::REG_W
) (
    input  logic             in_valid,
    input  logic             y_valid,
    input  logic             y_mem_read,
    input  logic [REG_W-1:0] y_rt,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    output logic             haz
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign haz = in_valid && y_valid && y_mem_read && (y_rt != {REG_W{1'b0}})
              && ((y_rt == in_rs) || (y_rt == in_rt));

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, sync flush and load-use bubble insertion.
// Optional macro ID_EX_SKID_EN adds a one-entry skid buffer that removes the out_ready -> in_ready path.
module id_ex_pipe_stage #(
    parameter int DATA_W  = id_ex_pkg::DATA_W,
    parameter int REG_W   = id_ex_pkg::REG_W,
    parameter int CTRL_W  = id_ex_pkg::CTRL_W,
    parameter int ALUOP_W = id_ex_pkg::ALUOP_W,
    parameter int CNT_W   = id_ex_pkg::CNT_W
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_r1,
    input  logic [DATA_W-1:0]  in_r2,
    input  logic [DATA_W-1:0]  in_address,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [ALUOP_W-1:0] in_alu_ctrl,
    input  logic               in_mem_read,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_r1,
    output logic [DATA_W-1:0]  out_r2,
    output logic [DATA_W-1:0]  out_address,
    output logic [DATA_W-1:0]  out_pc,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [ALUOP_W-1:0] out_alu_ctrl,
    output logic               out_mem_read,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam int P_W = 4*DATA_W + CTRL_W + ALUOP_W + 1 + 3*REG_W;
    localparam int MR_BIT = 3*REG_W;
    // Bits that carry side effects: ctrl and mem_read must be zero in any invalid entry
    localparam logic [P_W-1:0] SIDE_MASK = {{(4*DATA_W){1'b0}}, {CTRL_W{1'b1}},
                                            {ALUOP_W{1'b0}}, 1'b1, {(3*REG_W){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [P_W-1:0] squash(input logic [P_W-1:0] p);
        return p & ~SIDE_MASK;
    endfunction

    logic [P_W-1:0]   in_payload_s;
    logic [P_W-1:0]   out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
    logic             advance_s, haz_s, accept_s, bubble_s;
    logic             y_valid_s, y_mem_read_s;
    logic [REG_W-1:0] y_rt_s;

    assign in_payload_s = {in_r1, in_r2, in_address, in_pc, in_ctrl, in_alu_ctrl,
                           in_mem_read, in_rd, in_rs, in_rt};
    assign advance_s    = !out_valid_q || out_ready;
    assign accept_s     = in_valid && in_ready;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .in_valid   (in_valid),
        .y_valid    (y_valid_s),
        .y_mem_read (y_mem_read_s),
        .y_rt       (y_rt_s),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .haz        (haz_s)
    );

`ifdef ID_EX_SKID_EN
    logic [P_W-1:0] skid_q, skid_d;
    logic           skid_valid_q, skid_valid_d;

    // The youngest stored entry is the skid whenever it is occupied
    assign y_valid_s    = skid_valid_q || out_valid_q;
    assign y_mem_read_s = skid_valid_q ? skid_q[MR_BIT] : out_q[MR_BIT];
    assign y_rt_s       = skid_valid_q ? skid_q[REG_W-1:0] : out_q[REG_W-1:0];
    assign in_ready     = !skid_valid_q && !haz_s && !flush;
    assign bubble_s     = haz_s && advance_s && !flush && !skid_valid_q;

    // Next-state for output and skid registers: flush, then drain skid, then accept
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_d        = squash(out_q);
            skid_valid_d = 1'b0;
            skid_d       = squash(skid_q);
        end else if (advance_s) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
                skid_d       = squash(skid_q);
            end else if (accept_s) begin
                out_d       = in_payload_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_d       = squash(out_q);
            end
        end else begin
            if (accept_s) begin
                skid_d       = in_payload_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_d       = skid_q;
            end
        end
    end

    // Skid register state
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= {P_W{1'b0}};
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign y_valid_s    = out_valid_q;
    assign y_mem_read_s = out_q[MR_BIT];
    assign y_rt_s       = out_q[REG_W-1:0];
    assign in_ready     = advance_s && !haz_s && !flush;
    assign bubble_s     = haz_s && advance_s && !flush;

    // Next-state for the output register; a non-accepting advance leaves a squashed, invalid entry
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_d       = squash(out_q);
        end else if (advance_s) begin
            if (accept_s) begin
                out_d       = in_payload_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_d       = squash(out_q);
            end
        end else begin
            out_d = out_q;
        end
    end
`endif

    // Saturating bubble counter, immune to flush
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (bubble_s && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + CNT_ONE;
        end else begin
            bubble_count_d = bubble_count_q;
        end
    end

    // Output register state
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= {P_W{1'b0}};
            out_valid_q    <= 1'b0;
            bubble_count_q <= {CNT_W{1'b0}};
        end else begin
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign {out_r1, out_r2, out_address, out_pc, out_ctrl, out_alu_ctrl,
            out_mem_read, out_rd, out_rs, out_rt} = out_q;
    assign out_valid      = out_valid_q;
    assign bubble_count   = bubble_count_q;
    assign load_use_stall = haz_s;

endmodule
